// File: rtl/cmp_arbiter_pkg.sv
// ============================================================================
// Module   : cmp_arbiter_pkg
// Purpose  : State encodings and default sizes shared by the compare arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_arbiter_pkg;

    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/comparator.sv
// ============================================================================
// Module   : comparator
// Purpose  : Unsigned magnitude/equality compare of two N-bit operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gr,
    output logic         le,
    output logic         eq
);

    assign gr = (a > b);
    assign le = (a < b);
    assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/cmp_arbiter.sv
// ============================================================================
// Module   : cmp_arbiter
// Purpose  : Round-robin arbiter sequencing NREQ requesters onto one shared
//            comparator; returns a registered, id-tagged gr/le/eq result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gr,
    output logic              rsp_le,
    output logic              rsp_eq,
    output logic              busy
);

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_gnt_id;
    logic [N-1:0]     r_op_a;
    logic [N-1:0]     r_op_b;
    logic             r_res_gr;
    logic             r_res_le;
    logic             r_res_eq;

    logic             w_cmp_gr;
    logic             w_cmp_le;
    logic             w_cmp_eq;
    logic             w_any;
    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_shift;
    logic [NREQ-1:0]  w_rot;
    logic [IDW-1:0]   w_enc;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_gnt;
    logic [N-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_b;
    logic [IDW-1:0]   w_ptr_nxt;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        w_any   = |req_valid;
        w_dbl   = {req_valid, req_valid};
        w_shift = w_dbl >> r_rr_ptr;
        w_rot   = w_shift[NREQ-1:0];
        w_enc   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_enc = IDW'(k);
            end
        end
        w_sum = {1'b0, w_enc} + {1'b0, r_rr_ptr};
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_gnt = IDW'(w_sum - (IDW+1)'(NREQ));
        end else begin
            w_gnt = w_sum[IDW-1:0];
        end
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_gnt) begin
                w_sel_a = req_a[k*N +: N];
                w_sel_b = req_b[k*N +: N];
            end
        end
    end

    assign w_ptr_nxt = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

    comparator #(
        .N (N)
    ) u_comparator (
        .a  (r_op_a),
        .b  (r_op_b),
        .gr (w_cmp_gr),
        .le (w_cmp_le),
        .eq (w_cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_res_gr <= 1'b0;
            r_res_le <= 1'b0;
            r_res_eq <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_gnt_id <= w_gnt;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_res_gr <= w_cmp_gr;
                    r_res_le <= w_cmp_le;
                    r_res_eq <= w_cmp_eq;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_rr_ptr <= w_ptr_nxt;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, except the accept pulse.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_id    = '0;
        rsp_gr    = 1'b0;
        rsp_le    = 1'b0;
        rsp_eq    = 1'b0;
        if (r_state == ST_IDLE && w_any) begin
            req_ready = NREQ'(1) << w_gnt;
        end
        if (r_state == ST_RESP) begin
            rsp_valid = NREQ'(1) << r_gnt_id;
            rsp_id    = r_gnt_id;
            rsp_gr    = r_res_gr;
            rsp_le    = r_res_le;
            rsp_eq    = r_res_eq;
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// Module   : tb_cmp_arbiter
// Purpose  : Directed, table-driven self-checking bench for cmp_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_gr;
    logic              rsp_le;
    logic              rsp_eq;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    cmp_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gr    (rsp_gr),
        .rsp_le    (rsp_le),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;   // {gr, le, eq}
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Caller has set operands; runs one transaction with the given valid mask.
    task automatic txn(input string name, input logic [3:0] mask, input int exp_id,
                       input logic [2:0] exp_flags);
        bit got = 0;
        req_valid = mask;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
            else step();
        end
        check({name, " ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
        step();
        req_valid = '0;
        @(negedge clk);
        check({name, " cmp busy/ready/rsp"}, {busy, req_ready, rsp_valid}, {1'b1, 4'b0, 4'b0});
        @(negedge clk);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'(4'b0001 << exp_id));
        check({name, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({name, " flags"}, 32'({rsp_gr, rsp_le, rsp_eq}), 32'(exp_flags));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] fair_flags [4];
        tbl[0] = '{0, 8'h80, 8'h7F, 3'b100};
        tbl[1] = '{1, 8'hFF, 8'h00, 3'b100};
        tbl[2] = '{2, 8'h00, 8'hFF, 3'b010};
        tbl[3] = '{3, 8'h5A, 8'h5A, 3'b001};
        tbl[4] = '{0, 8'h00, 8'h00, 3'b001};
        tbl[5] = '{2, 8'h01, 8'h02, 3'b010};
        fair_flags[0] = 3'b010;
        fair_flags[1] = 3'b010;
        fair_flags[2] = 3'b001;
        fair_flags[3] = 3'b100;

        do_reset();
        @(negedge clk);
        check("reset outputs",
              {req_ready, rsp_valid, 2'(rsp_id), rsp_gr, rsp_le, rsp_eq, busy},
              {4'b0, 4'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        step();

        for (int i = 0; i < 6; i++) begin
            req_a[tbl[i].id*N +: N] = tbl[i].a;
            req_b[tbl[i].id*N +: N] = tbl[i].b;
            txn($sformatf("vec%0d", i), 4'(1 << tbl[i].id), tbl[i].id, tbl[i].flags);
        end
        @(negedge clk);
        check("idle after rsp", {busy, rsp_valid}, {1'b0, 4'b0});
        step();

        // Fairness: all valid, grants every third cycle in rotation.
        do_reset();
        req_a = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b = {8'd2, 8'd2, 8'd2, 8'd2};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check($sformatf("fair%0d ready", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
            step();
            @(negedge clk);
            check($sformatf("fair%0d cmp ready", g), 32'(req_ready), 32'd0);
            step();
            @(negedge clk);
            check($sformatf("fair%0d resp ready", g), 32'(req_ready), 32'd0);
            check($sformatf("fair%0d rsp_id", g), 32'(rsp_id), 32'(g % 4));
            check($sformatf("fair%0d flags", g), 32'({rsp_gr, rsp_le, rsp_eq}),
                  32'(fair_flags[g % 4]));
            step();
        end
        req_valid = '0;

        // Wrap: after granting 2 the pointer is 3, so 0101 picks 0.
        do_reset();
        req_a = {8'd9, 8'd7, 8'd4, 8'd1};
        req_b = {8'd9, 8'd7, 8'd4, 8'd1};
        txn("wrap pre", 4'b0100, 2, 3'b001);
        txn("wrap", 4'b0101, 0, 3'b001);

        // Reset in the CMP cycle drops the response and clears the pointer.
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        check("rst-mid ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst-mid after", {busy, rsp_valid}, {1'b0, 4'b0});
        step();
        @(negedge clk);
        check("rst-mid no rsp", {busy, rsp_valid}, {1'b0, 4'b0});
        step();
        txn("rst-mid next", 4'b1010, 1, 3'b001);

        // Withdrawal of requester 3 plus operand change after acceptance.
        do_reset();
        req_a = {8'd5, 8'd0, 8'd0, 8'd10};
        req_b = {8'd5, 8'd0, 8'd0, 8'd20};
        req_valid = 4'b1001;
        @(negedge clk);
        check("wd ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1000;
        req_a[7:0] = 8'hFF;
        @(negedge clk);
        check("wd cmp ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("wd rsp", {rsp_valid, 2'(rsp_id), rsp_gr, rsp_le, rsp_eq},
              {4'b0001, 2'd0, 3'b010});
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("wd idle%0d", k), {busy, req_ready, rsp_valid}, {1'b0, 4'b0, 4'b0});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
